// File: rtl/code_dec_pkg.sv
// Shared types and helpers for the sequenced 2-to-4 code decoder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package code_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // 2-bit index to 4-bit one-hot line; also usable as a reference by encoder benches
  function automatic logic [3:0] onehot4(input logic [1:0] code);
    onehot4 = 4'b0001 << code;
  endfunction

endpackage

// File: rtl/code_dec_2x4_seq_skid.sv
// One-entry holding buffer for the next code while the current pulse is driven.
// Latency: a write is visible on pend_valid/pend_code the cycle after the edge.
// Backpressure: ready drops while the entry is occupied; a write wins over a read.
module code_skid_1 (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_code,
  input  logic       rd_en,
  output logic       pend_valid,
  output logic [1:0] pend_code,
  output logic       ready
);

  // Entry register: a same-edge write replaces a consumed entry, keeping it valid
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_code  <= 2'd0;
    end else if (wr_en) begin
      pend_valid <= 1'b1;
      pend_code  <= wr_code;
    end else if (rd_en) begin
      pend_valid <= 1'b0;
    end
  end

  // Ready comes from the register only, so upstream sees no path from its own valid
  always_comb begin
    ready = !pend_valid;
  end

endmodule

// File: rtl/code_dec_2x4_seq.sv
// Sequenced 2-to-4 decoder: drives one-hot line for HOLD_CYCLES, then GAP_CYCLES of zeros.
// Latency: code accepted at edge k in IDLE drives cycles k+1..k+HOLD_CYCLES, done in the last.
// Backpressure: in_ready = !pend_valid; one further code may queue while a pulse is running.
module code_dec_2x4_seq
  import code_dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_code,
  output logic       in_ready,
  output logic [3:0] out_onehot,
  output logic       out_active,
  output logic       done
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       cur_code, cur_code_nxt;
  logic             accept;
  logic             take_src;
  logic             pend_valid;
  logic [1:0]       pend_code;
  logic             pend_wr;
  logic             pend_rd;

  assign accept = in_valid && in_ready;

  // A code bypasses the buffer when the FSM can start it immediately and nothing is queued
  assign pend_rd = take_src && pend_valid;
  assign pend_wr = accept && (state != IDLE) && !(take_src && !pend_valid);

  code_skid_1 u_skid (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (pend_wr),
    .wr_code    (in_code),
    .rd_en      (pend_rd),
    .pend_valid (pend_valid),
    .pend_code  (pend_code),
    .ready      (in_ready)
  );

  // State, counter and current code registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_code <= 2'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_code <= cur_code_nxt;
    end
  end

  // Next-state: count down each phase, then pick the next code (queued first, then fresh)
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cur_code_nxt = cur_code;
    take_src     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt    = DRIVE;
          cur_code_nxt = in_code;
          cnt_nxt      = HOLD_LD;
        end
      end
      DRIVE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (GAP_CYCLES > 0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          take_src = 1'b1;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          take_src = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (take_src) begin
      if (pend_valid) begin
        state_nxt    = DRIVE;
        cur_code_nxt = pend_code;
        cnt_nxt      = HOLD_LD;
      end else if (accept) begin
        state_nxt    = DRIVE;
        cur_code_nxt = in_code;
        cnt_nxt      = HOLD_LD;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end
  end

  // Outputs decoded from registers only
  always_comb begin
    out_onehot = 4'b0000;
    out_active = 1'b0;
    done       = 1'b0;
    if (state == DRIVE) begin
      out_onehot = onehot4(cur_code);
      out_active = 1'b1;
      done       = (cnt == '0);
    end
  end

endmodule

// File: tb/tb_code_dec_2x4_seq.sv
// Bench for code_dec_2x4_seq: directed scenarios plus random traffic against a slot-based model.
// Latency: n/a.
// Backpressure: stimulus holds a code until it is accepted.
module tb_code_dec_2x4_seq;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_code;
  logic       sel;

  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [3:0] a_oh, b_oh;
  logic       a_act, b_act, a_done, b_done;
  logic       obs_ready, obs_act, obs_done;
  logic [3:0] obs_oh;

  int checks = 0;
  int errors = 0;

  // Slot model: a pulse occupies H drive cycles followed by g gap cycles
  int g;
  bit m_busy;
  int m_pos;
  int m_cur;
  int m_q[$];

  always #5 clk = ~clk;

  assign a_valid   = (sel == 1'b0) ? in_valid : 1'b0;
  assign b_valid   = (sel == 1'b1) ? in_valid : 1'b0;
  assign obs_ready = sel ? b_ready : a_ready;
  assign obs_oh    = sel ? b_oh    : a_oh;
  assign obs_act   = sel ? b_act   : a_act;
  assign obs_done  = sel ? b_done  : a_done;

  code_dec_2x4_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_code(in_code),
    .in_ready(a_ready), .out_onehot(a_oh), .out_active(a_act), .done(a_done)
  );

  code_dec_2x4_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_code(in_code),
    .in_ready(b_ready), .out_onehot(b_oh), .out_active(b_act), .done(b_done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare outputs against the model, then advance the model on the edge
  task automatic cycle(output bit acc);
    bit drv;
    int exp_rdy;
    drv     = m_busy && (m_pos < H);
    exp_rdy = (m_q.size() == 0) ? 1 : 0;
    check("in_ready",   int'(obs_ready), exp_rdy);
    check("out_onehot", int'(obs_oh),    drv ? (1 << m_cur) : 0);
    check("out_active", int'(obs_act),   drv ? 1 : 0);
    check("done",       int'(obs_done),  (drv && m_pos == H - 1) ? 1 : 0);
    acc = in_valid && (exp_rdy == 1) && !rst;
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_pos  = 0;
      m_q.delete();
    end else if (!m_busy) begin
      if (acc) begin
        m_busy = 1'b1;
        m_pos  = 0;
        m_cur  = int'(in_code);
      end
    end else if (m_pos != H + g - 1) begin
      m_pos++;
      if (acc) m_q.push_back(int'(in_code));
    end else if (m_q.size() != 0) begin
      m_cur = m_q.pop_front();
      m_pos = 0;
      if (acc) m_q.push_back(int'(in_code));
    end else if (acc) begin
      m_cur = int'(in_code);
      m_pos = 0;
    end else begin
      m_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic send(input logic [1:0] code);
    bit acc;
    in_valid = 1'b1;
    in_code  = code;
    cycle(acc);
    in_valid = 1'b0;
  endtask

  // Hold valid high with codes first..first+n-1, advancing only on accept
  task automatic stream(input int first, input int n, input string tag);
    bit acc;
    int idx;
    idx      = 0;
    in_valid = 1'b1;
    in_code  = 2'(first);
    for (int c = 0; c < 100 && idx < n; c++) begin
      cycle(acc);
      if (acc) begin
        idx++;
        in_code = 2'(first + idx);
      end
    end
    in_valid = 1'b0;
    check(tag, idx, n);
  endtask

  task automatic do_reset(input int n);
    bit acc;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_code  = 2'd3;
    for (int i = 0; i < n; i++) cycle(acc);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic random_run(input int n);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < n; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!(in_valid && !acc)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_code  = 2'($urandom_range(0, 3));
      end
      cycle(acc);
    end
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    sel      = 1'b0;
    g        = 1;
    m_busy   = 1'b0;
    m_pos    = 0;
    m_cur    = 0;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_code  = 2'd2;
    @(negedge clk);

    // Reset held with valid high: nothing may be accepted
    do_reset(2);
    idle(2);

    // Single code 2: four cycles of 0100, done on the fourth
    send(2'd2);
    idle(7);

    // Buffered pair: code 3, then code 0 two cycles later
    send(2'd3);
    idle(1);
    send(2'd0);
    idle(12);

    // Backpressure: codes 1,2,3 offered continuously
    stream(1, 3, "bp_accepts");
    idle(16);

    // Mid-pulse reset with a code pending
    send(2'd1);
    in_valid = 1'b1;
    in_code  = 2'd2;
    cycle(acc);
    in_valid = 1'b0;
    rst      = 1'b1;
    cycle(acc);
    rst      = 1'b0;
    check("post_rst_onehot", int'(a_oh), 0);
    idle(10);

    random_run(600);
    do_reset(1);
    idle(12);

    // Seamless pulses without a gap: 1 drives, 2 queued, 3 waits for the buffer
    sel = 1'b1;
    g   = 0;
    do_reset(2);
    stream(1, 3, "gap0_accepts");
    idle(14);

    random_run(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/code_dec_2x4_seq.md
# code_dec_2x4_seq

Sequenced 2-to-4 decoder: the receiving end of the 4x2 priority encoder's code/valid output. It accepts a 2-bit code with a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. An optional idle gap separates consecutive pulses, and a one-entry buffer lets the upstream encoder present the next code while the current one is still being driven. It sits between encoder-side request logic and the per-line consumers, such as strobe or enable inputs.

## Interface
- HOLD_CYCLES, 4, cycles each one-hot pulse stays asserted; legal range 1..255.
- GAP_CYCLES, 1, all-zero cycles forced after each pulse; legal range 0..255.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  code present; driven by the encoder's z output.
- in_code  input  2  encoded index; driven by the encoder's y output.
- in_ready  output  1  block can accept a code this cycle.
- out_onehot  output  4  decoded line; bit in_code set while driving, otherwise 4'b0000.
- out_active  output  1  high during every DRIVE cycle.
- done  output  1  high during the final DRIVE cycle of each pulse.

## Operation
- The FSM has three states:
  - IDLE: outputs zero.
  - DRIVE: out_onehot = 1 << cur_code, out_active = 1.
  - GAP: outputs zero.
- Registers:
  - state
  - cur_code[1:0]
  - cnt, width $clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1)
  - pend_valid, pend_code[1:0]
- Accept condition: an accept occurs when in_valid && in_ready at a rising edge.
- in_ready = !pend_valid. It is decoded from registers only and has no combinational path from in_valid.
- IDLE with accept: next state DRIVE, cur_code = in_code, cnt = HOLD_CYCLES-1. The buffer is bypassed.
- DRIVE with cnt != 0: decrement cnt.
- DRIVE with cnt == 0 (the done cycle):
  - If GAP_CYCLES > 0: go to GAP with cnt = GAP_CYCLES-1.
  - If GAP_CYCLES == 0: take the next source directly.
- GAP with cnt != 0: decrement cnt.
- GAP with cnt == 0: take the next source.
- Next-source rule, in priority order:
  1. pend_code if pend_valid.
  2. Otherwise the code accepted this cycle.
  3. Otherwise go to IDLE.
  - When a source is taken, the next state is DRIVE with cnt = HOLD_CYCLES-1.
- Accept while in DRIVE or GAP: the code is written to pend. If the buffer is consumed in the same cycle, the new code replaces it and pend_valid stays 1.
- Accept while in_valid=0: nothing happens. in_code is a don't-care.
- Reset: state = IDLE, cnt = 0, cur_code = 0, pend_valid = 0, pend_code = 0.
  - Output values in reset: out_onehot = 0, out_active = 0, done = 0, in_ready = 1.
  - Reset asserted mid-pulse aborts the pulse with no done, and discards any pending code.

## Timing
- Latency: a code accepted at edge k in IDLE gives out_onehot valid in cycles k+1 .. k+HOLD_CYCLES. done is high in cycle k+HOLD_CYCLES.
- Pulse spacing: the next pulse starts GAP_CYCLES cycles after the previous done cycle.
- Back-to-back pulses with GAP_CYCLES = 0 are seamless. out_onehot changes directly from one code to the next with no zero cycle, and out_active stays high.
- Throughput: at most one code per HOLD_CYCLES + GAP_CYCLES cycles. in_ready deasserts while a code is pending.
- All outputs are registered or decoded from registers only. No combinational input-to-output path exists.

## Structure
- Shared package code_dec_pkg holds:
  - the state enum (IDLE, DRIVE, GAP);
  - a onehot4 function (2-bit code to 4-bit one-hot), also reusable by encoder benches as the reference model.
- The one-entry buffer (pend_valid/pend_code, with ready logic) is a natural sub-module named code_skid_1. The FSM, counter and decode stay in the top module.

## Test plan
All scenarios use HOLD_CYCLES = 4, GAP_CYCLES = 1.
- Reset: hold rst for 2 cycles with in_valid = 1. Required: out_onehot = 0, in_ready = 1, done = 0 throughout. No accept takes effect.
- Single code: in_code = 2'b10 with in_valid pulsed for 1 cycle in IDLE. Required: out_onehot = 4'b0100 for exactly 4 cycles starting the next cycle, done in the 4th cycle, then IDLE.
- Buffered pair: accept code 3, then accept code 0 two cycles later. Required:
  - 4'b1000 for 4 cycles;
  - one 4'b0000 gap cycle;
  - 4'b0001 for 4 cycles;
  - in_ready low from the cycle after the second accept until the second pulse starts.
- Backpressure: hold in_valid = 1 with codes 1, 2, 3 while pend is full. Required: each code is accepted only when in_ready = 1, and the pulses appear in order 0010, 0100, 1000 with none lost.
- Simultaneous event, rerun with GAP_CYCLES = 0: accept a new code on the same edge the pending code is consumed. Required: the pending code drives next, the new code is held in pend, and out_onehot shows no zero cycle between pulses.
- Mid-pulse reset: assert rst in the 2nd DRIVE cycle with a code pending. Required: outputs zero the next cycle, no done, and the pending code is discarded.
